data_reg_file: RTL and testbench

Parametrised register file that succeeds the single 16-bit data register and holds the processor's general-purpose register set. It provides one synchronous write port and two registered read ports, with an optional hardwired-zero register and a compile-time write-to-read bypass. It sits between instruction decode (addresses) and the ALU operand muxes (read data), and takes writeback from the result mux.

---
 rtl/data_reg_pkg.sv | 20 ++
 rtl/data_reg_word.sv | 30 +++
 rtl/data_reg_file.sv | 107 ++++++++++
 tb/tb_data_reg_file.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/data_reg_pkg.sv
// Shared definitions for the general-purpose register file:
// default geometry, the data word type and the address-width helper.
package data_reg_pkg;

    localparam int DEFAULT_WIDTH = 32'sd16;
    localparam int DEFAULT_DEPTH = 32'sd16;

    typedef logic [DEFAULT_WIDTH-1:0] data_word_t;

    // Ceiling log2, used to size addresses from a register count.
    function automatic int clog2(input int value);
        int result;
        result = 32'sd0;
        for (int v = value - 32'sd1; v > 32'sd0; v = v >>> 32'sd1) begin
            result = result + 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/data_reg_word.sv
// One register of the file: synchronous active-high reset and a load enable.
// Reset wins over load so a write coinciding with reset is dropped.
module data_reg_word
    import data_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_r;

    // Storage flop: clear on reset, capture d when loaded, otherwise hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            q_r <= '0;
        end else if (load) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/data_reg_file.sv
// General-purpose register file: one synchronous write port, two registered
// read ports, optional hardwired-zero register 0.
// Optional feature: define DATA_REG_FILE_BYPASS_EN to forward a same-edge
// write to a read port addressing the same register; otherwise reads on that
// edge return the old contents (read-before-write).
module data_reg_file
    import data_reg_pkg::*;
#(
    parameter int   WIDTH    = DEFAULT_WIDTH,
    parameter int   DEPTH    = DEFAULT_DEPTH,
    parameter bit   ZERO_REG = 1'b1,
    localparam int  ADDR_W   = clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic [WIDTH-1:0]  rd_data_b
);

    // One past the highest legal address, one bit wider so DEPTH itself fits.
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] word_q_s;
    logic [DEPTH-1:0]            load_s;
    logic                        wr_in_range_s;
    logic                        wr_masked_s;
    logic                        wr_ok_s;
    logic [WIDTH-1:0]            rd_mux_a_s;
    logic [WIDTH-1:0]            rd_mux_b_s;
    logic                        byp_a_s;
    logic                        byp_b_s;
    logic [WIDTH-1:0]            rd_a_r;
    logic [WIDTH-1:0]            rd_b_r;

    // AND-OR read mux: an address matching no instantiated word yields zero,
    // which covers out-of-range addresses on non power-of-two depths.
    function automatic logic [WIDTH-1:0] read_mux(
        input logic [ADDR_W-1:0]             addr,
        input logic [DEPTH-1:0][WIDTH-1:0]   words
    );
        logic [WIDTH-1:0] result;
        result = '0;
        for (int i = 0; i < DEPTH; i++) begin
            result = result | (words[i] & {WIDTH{addr == ADDR_W'(i)}});
        end
        return result;
    endfunction

    // A write takes effect only for in-range addresses and never for the
    // hardwired-zero register.
    assign wr_in_range_s = ({1'b0, wr_addr} < DEPTH_LIM);
    assign wr_masked_s   = ZERO_REG && (wr_addr == '0);
    assign wr_ok_s       = wr_en && wr_in_range_s && !wr_masked_s;

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        if (ZERO_REG && (i == 32'sd0)) begin : g_zero
            assign load_s[i]   = 1'b0;
            assign word_q_s[i] = '0;
        end else begin : g_reg
            assign load_s[i] = wr_ok_s && (wr_addr == ADDR_W'(i));
            data_reg_word #(
                .WIDTH (WIDTH)
            ) u_word (
                .clock (clock),
                .reset (reset),
                .load  (load_s[i]),
                .d     (wr_data),
                .q     (word_q_s[i])
            );
        end
    end

    // Select stored words for both read ports.
    always_comb begin
        rd_mux_a_s = read_mux(rd_addr_a, word_q_s);
        rd_mux_b_s = read_mux(rd_addr_b, word_q_s);
    end

`ifdef DATA_REG_FILE_BYPASS_EN
    // Each port independently forwards an accepted same-edge write.
    assign byp_a_s = wr_ok_s && (wr_addr == rd_addr_a);
    assign byp_b_s = wr_ok_s && (wr_addr == rd_addr_b);
`else
    assign byp_a_s = 1'b0;
    assign byp_b_s = 1'b0;
`endif

    // Read output registers: cleared by reset, otherwise updated every edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_a_r <= '0;
            rd_b_r <= '0;
        end else begin
            rd_a_r <= byp_a_s ? wr_data : rd_mux_a_s;
            rd_b_r <= byp_b_s ? wr_data : rd_mux_b_s;
        end
    end

    assign rd_data_a = rd_a_r;
    assign rd_data_b = rd_b_r;

endmodule

// File: tb/tb_data_reg_file.sv
// Self-checking bench for data_reg_file. Three instances share one stimulus
// stream: default (DEPTH 16, zero reg), ZERO_REG=0, and DEPTH=12.
// A reference model predicts each read; predictions are queued when driven
// and popped when the registered outputs appear one edge later.
module tb_data_reg_file;

    logic        clock;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [3:0]  rd_addr_a;
    logic [3:0]  rd_addr_b;
    logic [15:0] out_a [3];
    logic [15:0] out_b [3];

    int checks;
    int failures;

`ifdef DATA_REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        string       tag;
        int          d;
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    exp_t        sb [$];
    logic [15:0] mem [3][16];
    int          depth_m [3] = '{16, 16, 12};
    bit          zr_m [3]    = '{1'b1, 1'b0, 1'b1};

    data_reg_file #(.WIDTH(16), .DEPTH(16), .ZERO_REG(1'b1)) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(out_a[0]), .rd_data_b(out_b[0]));

    data_reg_file #(.WIDTH(16), .DEPTH(16), .ZERO_REG(1'b0)) dut_nz (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(out_a[1]), .rd_data_b(out_b[1]));

    data_reg_file #(.WIDTH(16), .DEPTH(12), .ZERO_REG(1'b1)) dut_d12 (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(out_a[2]), .rd_data_b(out_b[2]));

    // Free-running clock, 10 time-unit period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_value(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    function automatic bit wr_valid(input int d, input logic [3:0] a);
        return (int'(a) < depth_m[d]) && !(zr_m[d] && (a == 4'd0));
    endfunction

    function automatic logic [15:0] model_rd(input int d, input logic [3:0] a);
        if (int'(a) >= depth_m[d]) return 16'h0000;
        if (zr_m[d] && (a == 4'd0)) return 16'h0000;
        return mem[d][a];
    endfunction

    function automatic logic [15:0] predict(input int d, input logic rst, input logic we,
                                            input logic [3:0] wa, input logic [15:0] wd,
                                            input logic [3:0] ra);
        if (rst) return 16'h0000;
        if (BYP && we && wr_valid(d, wa) && (wa == ra)) return wd;
        return model_rd(d, ra);
    endfunction

    // One clock: drive, queue predictions, advance model, pop and compare.
    task automatic step(input string tag, input logic rst, input logic we,
                        input logic [3:0] wa, input logic [15:0] wd,
                        input logic [3:0] ra, input logic [3:0] rb);
        exp_t e;
        @(negedge clock);
        reset     = rst;
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        rd_addr_a = ra;
        rd_addr_b = rb;
        for (int d = 0; d < 3; d++) begin
            e.tag = tag;
            e.d   = d;
            e.a   = predict(d, rst, we, wa, wd, ra);
            e.b   = predict(d, rst, we, wa, wd, rb);
            sb.push_back(e);
        end
        @(posedge clock);
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                for (int k = 0; k < 16; k++) mem[d][k] = 16'h0000;
            end else if (we && wr_valid(d, wa)) begin
                mem[d][wa] = wd;
            end
        end
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_value($sformatf("%s_a_dut%0d", e.tag, e.d), out_a[e.d], e.a);
            check_value($sformatf("%s_b_dut%0d", e.tag, e.d), out_b[e.d], e.b);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = 4'd0;
        wr_data   = 16'h0000;
        rd_addr_a = 4'd0;
        rd_addr_b = 4'd0;
        for (int d = 0; d < 3; d++)
            for (int k = 0; k < 16; k++) mem[d][k] = 16'h0000;

        // Reset state and post-reset zeros.
        step("rst0", 1'b1, 1'b0, 4'd0, 16'h0000, 4'd0, 4'd0);
        check_value("reset_a", out_a[0], 16'h0000);
        step("post_rst", 1'b0, 1'b0, 4'd0, 16'h0000, 4'd5, 4'd9);

        // Reset clears stored data.
        step("w5", 1'b0, 1'b1, 4'd5, 16'hBEEF, 4'd0, 4'd0);
        step("r5", 1'b0, 1'b0, 4'd0, 16'h0000, 4'd5, 4'd5);
        check_value("r5_before_rst", out_a[0], 16'hBEEF);
        step("rst1", 1'b1, 1'b0, 4'd0, 16'h0000, 4'd5, 4'd5);
        step("r5_after", 1'b0, 1'b0, 4'd0, 16'h0000, 4'd5, 4'd5);
        check_value("rst_clr_a", out_a[0], 16'h0000);
        check_value("rst_clr_b", out_b[0], 16'h0000);

        // Basic write/read.
        step("w3", 1'b0, 1'b1, 4'd3, 16'h001B, 4'd0, 4'd0);
        step("w7", 1'b0, 1'b1, 4'd7, 16'hFFFF, 4'd0, 4'd0);
        step("r3r7", 1'b0, 1'b0, 4'd0, 16'h0000, 4'd3, 4'd7);
        check_value("basic_a", out_a[0], 16'h001B);
        check_value("basic_b", out_b[0], 16'hFFFF);

        // Zero register.
        step("w0", 1'b0, 1'b1, 4'd0, 16'h1234, 4'd0, 4'd0);
        step("r0", 1'b0, 1'b0, 4'd0, 16'h0000, 4'd0, 4'd0);
        check_value("zero_reg_on", out_a[0], 16'h0000);
        check_value("zero_reg_off", out_a[1], 16'h1234);

        // Same-edge collision.
        step("w4", 1'b0, 1'b1, 4'd4, 16'h0001, 4'd0, 4'd0);
        step("coll", 1'b0, 1'b1, 4'd4, 16'h00AA, 4'd4, 4'd7);
        check_value("coll_a", out_a[0], BYP ? 16'h00AA : 16'h0001);
        step("coll_next", 1'b0, 1'b0, 4'd0, 16'h0000, 4'd4, 4'd4);
        check_value("coll_next_a", out_a[0], 16'h00AA);

        // Reset versus write.
        step("w2_rst", 1'b1, 1'b1, 4'd2, 16'h5555, 4'd2, 4'd2);
        step("r2", 1'b0, 1'b0, 4'd0, 16'h0000, 4'd2, 4'd2);
        check_value("rst_vs_wr", out_a[0], 16'h0000);

        // Out of range on DEPTH=12.
        step("w11", 1'b0, 1'b1, 4'd11, 16'h1111, 4'd0, 4'd0);
        step("w13", 1'b0, 1'b1, 4'd13, 16'h7777, 4'd0, 4'd0);
        step("r13r11", 1'b0, 1'b0, 4'd0, 16'h0000, 4'd13, 4'd11);
        check_value("oor_13", out_a[2], 16'h0000);
        check_value("oor_11", out_b[2], 16'h1111);
        check_value("inrange_13", out_a[0], 16'h7777);

        // Random traffic with occasional reset and same-address reads.
        for (int n = 0; n < 300; n++) begin
            logic [3:0] ra;
            ra = 4'($urandom_range(0, 15));
            step("rand", ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)),
                 16'($urandom), ra,
                 ($urandom_range(0, 3) == 0) ? ra : 4'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
